// File: rtl/memcopy_engine_pkg.sv
// Shared constants for the memcopy instruction: decoder encodings and the
// execution-unit state type.
package memcopy_engine_pkg;

   localparam logic [6:0] MEMCOPY_OPCODE = 7'b1111111;
   localparam logic [2:0] LS_MEMCOPY     = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_DONE
   } state_e;

endpackage : memcopy_engine_pkg

// File: rtl/memcopy_engine.sv
// Multi-cycle memcopy execution unit: owns the data-memory port while copying
// len words from src to dst, stalling the pipeline until the copy finishes.
module memcopy_engine
   import memcopy_engine_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  busy_o,
   output logic                  stall_o,
   output logic                  done_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [LEN_WIDTH-1:0]  cnt_q;
   logic [DATA_WIDTH-1:0] data_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  src_q <= src_addr_i;
                  dst_q <= dst_addr_i;
                  cnt_q <= len_i;
               end
            end
            ST_WAIT: data_q <= mem_rdata_i;
            ST_WRITE: begin
               // Address adders wrap modulo 2^ADDR_WIDTH by construction.
               src_q <= src_q + ADDR_STEP;
               dst_q <= dst_q + ADDR_STEP;
               cnt_q <= cnt_q - LEN_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output and next-state signal gets a default before the case,
   // so no path through this block can infer a latch.
   always_comb begin
      state_d     = state_q;
      mem_addr_o  = '0;
      mem_rd_en_o = 1'b0;
      mem_wr_en_o = 1'b0;
      mem_wdata_o = '0;
      stall_o     = 1'b0;
      done_o      = 1'b0;
      busy_o      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            // Stall in the accept cycle so EX holds the memcopy instruction.
            stall_o = start_i;
            if (start_i) begin
               state_d = (len_i == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            mem_addr_o  = src_q;
            mem_rd_en_o = 1'b1;
            stall_o     = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            stall_o = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            mem_addr_o  = dst_q;
            mem_wdata_o = data_q;
            mem_wr_en_o = 1'b1;
            stall_o     = 1'b1;
            state_d     = (cnt_q == LEN_WIDTH'(1)) ? ST_DONE : ST_READ;
         end
         ST_DONE: begin
            // Stall drops here so the pipeline retires alongside done_o.
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule : memcopy_engine

// File: tb/tb_memcopy_engine.sv
// Self-checking bench for memcopy_engine: a word-addressed memory model plus a
// cycle-by-cycle expectation derived from the copy timing rules.
module tb_memcopy_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [31:0] src_addr_i, dst_addr_i;
   logic [15:0] len_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] mem_addr_o;
   logic        mem_rd_en_o, mem_wr_en_o;
   logic [31:0] mem_wdata_o;
   logic        busy_o, stall_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem   [logic [31:0]];
   logic [31:0] model [logic [31:0]];

   logic [68:0] obs;
   assign obs = {busy_o, stall_o, done_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o};

   memcopy_engine #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .LEN_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .len_i      (len_i),
      .mem_rdata_i(mem_rdata_i),
      .mem_addr_o (mem_addr_o),
      .mem_rd_en_o(mem_rd_en_o),
      .mem_wr_en_o(mem_wr_en_o),
      .mem_wdata_o(mem_wdata_o),
      .busy_o     (busy_o),
      .stall_o    (stall_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // Unwritten locations read a deterministic address-derived pattern.
   function automatic logic [31:0] bg(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : bg(a);
   endfunction

   function automatic logic [31:0] model_val(input logic [31:0] a);
      return model.exists(a) ? model[a] : bg(a);
   endfunction

   // Synchronous memory: read data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en_o) mem_rdata_i <= mem_val(mem_addr_o);
      if (mem_wr_en_o) mem[mem_addr_o] = mem_wdata_o;
   end

   task automatic set_word(input logic [31:0] a, input logic [31:0] d);
      mem[a]   = d;
      model[a] = d;
   endtask

   task automatic drive_quiet();
      start_i    = 1'b0;
      src_addr_i = '0;
      dst_addr_i = '0;
      len_i      = '0;
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         drive_quiet();
         #1;
         n_checks++;
         if (obs !== 69'd0) begin
            n_fail++;
            $display("FAIL %s idle cycle %0d: outputs=%h required=%h", tag, j, obs, 69'd0);
         end
      end
   endtask

   // Drives one copy starting at the next negedge and checks every cycle
   // through DONE; returns just before the edge that leaves DONE.
   task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                           input int len, input int poke);
      int last = (len == 0) ? 1 : 3 * len + 1;
      for (int k = 0; k <= last; k++) begin
         logic        e_busy, e_stall, e_done, e_rd, e_wr;
         logic [31:0] e_addr, e_wdata;
         logic [68:0] exp_v;
         int          i;
         @(negedge clk);
         if (k == 0) begin
            start_i    = 1'b1;
            src_addr_i = src;
            dst_addr_i = dst;
            len_i      = 16'(len);
         end else if (k == poke) begin
            start_i    = 1'b1;
            src_addr_i = $urandom;
            dst_addr_i = $urandom;
            len_i      = 16'($urandom_range(1, 9));
         end else begin
            drive_quiet();
         end
         #1;
         {e_busy, e_stall, e_done, e_rd, e_wr} = '0;
         e_addr  = '0;
         e_wdata = '0;
         if (k == 0) begin
            e_stall = 1'b1;
         end else if (k == last) begin
            e_busy = 1'b1;
            e_done = 1'b1;
         end else begin
            e_busy  = 1'b1;
            e_stall = 1'b1;
            i = (k - 1) / 3;
            case ((k - 1) % 3)
               0: begin
                  e_rd   = 1'b1;
                  e_addr = src + 32'(4 * i);
               end
               2: begin
                  e_wr    = 1'b1;
                  e_addr  = dst + 32'(4 * i);
                  e_wdata = model_val(src + 32'(4 * i));
                  model[e_addr] = e_wdata;
               end
               default: ;
            endcase
         end
         exp_v = {e_busy, e_stall, e_done, e_rd, e_wr, e_addr, e_wdata};
         n_checks++;
         if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: {busy,stall,done,rd,wr,addr,wdata}=%h required=%h",
                     tag, k, obs, exp_v);
         end
      end
      begin
         int bad = 0;
         for (int i = 0; i < len; i++)
            if (mem_val(dst + 32'(4 * i)) !== model_val(dst + 32'(4 * i))) bad++;
         n_checks++;
         if (bad != 0) begin
            n_fail++;
            $display("FAIL %s dst contents: %0d wrong words, required 0", tag, bad);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_quiet();
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== 69'd0) begin
         n_fail++;
         $display("FAIL reset_state: outputs=%h required=%h", obs, 69'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_check("post_reset", 2);
   endtask

   task automatic test_plan_len3();
      set_word(32'h100, 32'hAAAA_0001);
      set_word(32'h104, 32'hBBBB_0002);
      set_word(32'h108, 32'hCCCC_0003);
      run_copy("len3", 32'h100, 32'h200, 3, -1);
      n_checks++;
      if ({mem_val(32'h200), mem_val(32'h204), mem_val(32'h208)} !==
          {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}) begin
         n_fail++;
         $display("FAIL len3_words: got %h %h %h required AAAA0001 BBBB0002 CCCC0003",
                  mem_val(32'h200), mem_val(32'h204), mem_val(32'h208));
      end
      idle_check("len3_after", 2);
   endtask

   task automatic test_len0();
      run_copy("len0", $urandom, $urandom, 0, -1);
      idle_check("len0_after", 2);
   endtask

   task automatic test_start_ignored();
      run_copy("ignore_start", 32'h1000, 32'h1800, 2, 4);
      idle_check("ignore_start_after", 3);
   endtask

   task automatic test_wrap();
      set_word(32'hFFFF_FFFC, 32'h1234_5678);
      set_word(32'h0000_0000, 32'h9ABC_DEF0);
      run_copy("wrap", 32'hFFFF_FFFC, 32'h0000_3000, 2, -1);
      idle_check("wrap_after", 1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] src = 32'h0000_5000;
      logic [31:0] dst = 32'h0000_5800;
      logic [31:0] w1_before;
      int          saw_done = 0;
      for (int i = 0; i < 4; i++) set_word(src + 32'(4 * i), $urandom);
      w1_before = mem_val(dst + 32'd4);
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start_i    = 1'b1;
            src_addr_i = src;
            dst_addr_i = dst;
            len_i      = 16'd4;
         end else begin
            drive_quiet();
         end
         if (k == 5) rst_n = 1'b0;
         #1;
         if (done_o === 1'b1) saw_done++;
      end
      n_checks++;
      if (obs !== 69'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: outputs=%h required=%h", obs, 69'd0);
      end
      @(negedge clk);
      #1;
      if (done_o === 1'b1) saw_done++;
      rst_n = 1'b1;
      n_checks++;
      if (saw_done != 0) begin
         n_fail++;
         $display("FAIL reset_mid_done: done pulses=%0d required 0", saw_done);
      end
      n_checks++;
      if (mem_val(dst) !== model_val(src) || mem_val(dst + 32'd4) !== w1_before) begin
         n_fail++;
         $display("FAIL reset_mid_words: w0=%h w1=%h required w0=%h w1=%h",
                  mem_val(dst), mem_val(dst + 32'd4), model_val(src), w1_before);
      end
      model[dst] = model_val(src);
      idle_check("reset_mid_release", 2);
      run_copy("after_reset", src, dst, 4, -1);
      idle_check("after_reset_idle", 1);
   endtask

   task automatic test_back_to_back();
      run_copy("b2b_a", 32'h0000_6000, 32'h0000_6800, 2, -1);
      run_copy("b2b_b", 32'h0000_6800, 32'h0000_7000, 3, -1);
      run_copy("b2b_c", 32'h0000_7000, 32'h0000_7800, 0, -1);
      run_copy("b2b_d", 32'h0000_7000, 32'h0000_7800, 1, -1);
      idle_check("b2b_after", 2);
   endtask

   task automatic test_random();
      for (int a = 0; a < 32; a++) set_word(32'h4000 + 32'(4 * a), $urandom);
      for (int n = 0; n < 10; n++) begin
         logic [31:0] src = 32'h4000 + 32'(4 * $urandom_range(0, 15));
         logic [31:0] dst = 32'h4000 + 32'(4 * $urandom_range(0, 15));
         int          len = $urandom_range(1, 6);
         int          gap = $urandom_range(0, 2);
         run_copy($sformatf("rand%0d", n), src, dst, len, (n % 3 == 0) ? 2 : -1);
         if (gap > 0) idle_check($sformatf("rand%0d_gap", n), gap);
      end
      idle_check("rand_after", 1);
   endtask

   initial begin
      mem_rdata_i = '0;
      drive_quiet();
      test_reset();
      test_plan_len3();
      test_len0();
      test_start_ignored();
      test_wrap();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_memcopy_engine
